// File: rtl/moore_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter (package arb_pkg).
// Holds the FSM state enum, default sizes and the rotate-back slot helper.
package arb_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Requester index sitting 'off' places after 'last' in circular order.
    // Scanning off = 1..n walks the rotated request vector from its lowest
    // bit upward and maps each rotated position back to a real index.
    function automatic int unsigned rr_slot(
        input int unsigned last,
        input int unsigned off,
        input int unsigned n
    );
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/moore_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker (module rr_pick).
// Ports: i_req request vector, i_last last grantee, o_valid any request, o_idx winner.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_idx
);

    // Walk from the farthest slot to the nearest so the slot closest
    // after i_last overwrites any earlier hit: lowest set bit of the
    // request vector rotated right by i_last+1.
    always_comb begin
        logic [ID_W-1:0] v_slot;
        v_slot  = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            v_slot = ID_W'(rr_slot(32'(i_last), k, N_REQ));
            if (i_req[v_slot]) begin
                o_valid = 1'b1;
                o_idx   = v_slot;
            end
        end
    end

endmodule

// File: rtl/moore_rr_arbiter.sv
// Moore round-robin arbiter: IDLE -> GRANT -> RELEASE, all outputs registered.
// Ports: clk, reset (async active-low), req in; gnt, gnt_id, busy, timeout out.
// Optional hold limit enabled by defining ARB_MAX_HOLD_EN.
module moore_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = DEF_N_REQ,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    if (N_REQ < 2 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("moore_rr_arbiter: need N_REQ >= 2 and MAX_HOLD >= 1");
    end

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  r_last;
    logic             r_busy;

    logic             w_valid;
    logic [ID_W-1:0]  w_pick;
    logic [N_REQ-1:0] w_pick_oh;
    logic             w_hold_hit;
    logic             w_release;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    assign w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_release = ~req[r_gnt_id] | w_hold_hit;

`ifdef ARB_MAX_HOLD_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // r_cnt counts completed GRANT cycles; the edge on which it would
    // reach MAX_HOLD is the one that forces the release.
    assign w_hold_hit = (r_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            // A grantee that dropped req on the limit edge left on its own.
            r_timeout <= (r_state == GRANT) & w_hold_hit & req[r_gnt_id];
            if (r_state == GRANT)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_hold_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_last   <= ID_W'(N_REQ - 1);
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state  <= GRANT;
                        r_gnt_id <= w_pick;
                        r_gnt    <= w_pick_oh;
                        r_busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= RELEASE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_gnt_id;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule
